// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the data cache: geometry, address field widths,
// controller state encoding and small datapath helpers.
package dcache_ctrl_pkg;

   localparam int NUM_BLOCKS    = 8;
   localparam int IDX_W         = $clog2(NUM_BLOCKS);
   localparam int ADDR_W        = 30;
   localparam int WORD_W        = 32;
   localparam int WORDS_PER_BLK = 4;
   localparam int BLK_W         = WORD_W * WORDS_PER_BLK;
   localparam int OFF_W         = 2;
   localparam int TAG_W         = ADDR_W - OFF_W - IDX_W;
   localparam int BADDR_W       = ADDR_W - OFF_W;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WB    = 2'd1,
      S_ALLOC = 2'd2
   } state_t;

   function automatic logic [WORD_W-1:0] blk_word(input logic [BLK_W-1:0] blk,
                                                  input logic [OFF_W-1:0] off);
      return blk[off*WORD_W +: WORD_W];
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/dcache_ctrl_line_array.sv
// Line storage for the direct-mapped cache: valid/dirty/tag/data per line,
// synchronous writes (word store or whole-line fill), asynchronous read.
module dcache_line_array
   import dcache_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [IDX_W-1:0]   i_idx,
   input  logic               i_wr_word,
   input  logic [OFF_W-1:0]   i_word_sel,
   input  logic [WORD_W-1:0]  i_wdata,
   input  logic               i_fill,
   input  logic [TAG_W-1:0]   i_fill_tag,
   input  logic [BLK_W-1:0]   i_fill_data,
   output logic               o_valid,
   output logic               o_dirty,
   output logic [TAG_W-1:0]   o_tag,
   output logic [BLK_W-1:0]   o_data
);

   logic [NUM_BLOCKS-1:0] r_valid;
   logic [NUM_BLOCKS-1:0] r_dirty;
   logic [TAG_W-1:0]      r_tag  [NUM_BLOCKS];
   logic [BLK_W-1:0]      r_data [NUM_BLOCKS];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else if (i_fill) begin
         r_valid[i_idx] <= 1'b1;
         r_dirty[i_idx] <= 1'b0;
      end else if (i_wr_word) begin
         r_dirty[i_idx] <= 1'b1;
      end
   end

   // Tag and data carry no reset; a cleared valid bit makes them don't-care.
   always_ff @(posedge clk) begin
      if (i_fill) begin
         r_tag[i_idx]  <= i_fill_tag;
         r_data[i_idx] <= i_fill_data;
      end else if (i_wr_word) begin
         r_data[i_idx][i_word_sel*WORD_W +: WORD_W] <= i_wdata;
      end
   end

   assign o_valid = r_valid[i_idx];
   assign o_dirty = r_dirty[i_idx];
   assign o_tag   = r_tag[i_idx];
   assign o_data  = r_data[i_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller.
// Define DCACHE_STATS_EN to add saturating hit/miss counters (stat_hit, stat_miss).
module dcache_ctrl
   import dcache_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               proc_read,
   input  logic               proc_write,
   input  logic [ADDR_W-1:0]  proc_addr,
   input  logic [WORD_W-1:0]  proc_wdata,
   output logic [WORD_W-1:0]  proc_rdata,
   output logic               proc_stall,
   output logic               mem_read,
   output logic               mem_write,
   output logic [BADDR_W-1:0] mem_addr,
   output logic [BLK_W-1:0]   mem_wdata,
   input  logic [BLK_W-1:0]   mem_rdata,
   input  logic               mem_ready
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]        stat_hit,
   output logic [31:0]        stat_miss
`endif
);

   state_t             r_state;
   state_t             w_next;
   logic [IDX_W-1:0]   w_idx;
   logic [TAG_W-1:0]   w_tag;
   logic [OFF_W-1:0]   w_off;
   logic               w_line_valid;
   logic               w_line_dirty;
   logic [TAG_W-1:0]   w_line_tag;
   logic [BLK_W-1:0]   w_line_data;
   logic               w_req;
   logic               w_hit;
   logic               w_hit_srv;
   logic               w_miss_ev;
   logic               w_wr_word;
   logic               w_fill;

   assign w_idx = proc_addr[IDX_W+OFF_W-1:OFF_W];
   assign w_tag = proc_addr[ADDR_W-1:IDX_W+OFF_W];
   assign w_off = proc_addr[OFF_W-1:0];
   assign w_req = proc_read | proc_write;
   assign w_hit = w_line_valid && (w_line_tag == w_tag);

   dcache_line_array u_lines (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_idx       (w_idx),
      .i_wr_word   (w_wr_word),
      .i_word_sel  (w_off),
      .i_wdata     (proc_wdata),
      .i_fill      (w_fill),
      .i_fill_tag  (w_tag),
      .i_fill_data (mem_rdata),
      .o_valid     (w_line_valid),
      .o_dirty     (w_line_dirty),
      .o_tag       (w_line_tag),
      .o_data      (w_line_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      proc_stall = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = proc_addr[ADDR_W-1:OFF_W];
      w_wr_word  = 1'b0;
      w_fill     = 1'b0;
      w_hit_srv  = 1'b0;
      w_miss_ev  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req) begin
               if (w_hit) begin
                  w_hit_srv = 1'b1;
                  w_wr_word = proc_write;
               end else begin
                  proc_stall = 1'b1;
                  w_miss_ev  = 1'b1;
                  w_next     = (w_line_valid && w_line_dirty) ? S_WB : S_ALLOC;
               end
            end
         end
         S_WB: begin
            proc_stall = 1'b1;
            mem_write  = 1'b1;
            mem_addr   = {w_line_tag, w_idx};
            if (mem_ready) w_next = S_ALLOC;
         end
         S_ALLOC: begin
            // The retried request hits in IDLE on the following cycle.
            proc_stall = 1'b1;
            mem_read   = 1'b1;
            if (mem_ready) begin
               w_fill = 1'b1;
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign mem_wdata  = w_line_data;
   assign proc_rdata = (w_hit_srv && !proc_write) ? blk_word(w_line_data, w_off) : '0;

`ifdef DCACHE_STATS_EN
   logic [31:0] r_stat_hit;
   logic [31:0] r_stat_miss;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stat_hit  <= '0;
         r_stat_miss <= '0;
      end else begin
         if (w_hit_srv) r_stat_hit  <= sat_inc(r_stat_hit);
         if (w_miss_ev) r_stat_miss <= sat_inc(r_stat_miss);
      end
   end

   assign stat_hit  = r_stat_hit;
   assign stat_miss = r_stat_miss;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a line-level cache model predicts memory
// traffic and load data; a monitor checks what the DUT presents against it.
module tb_dcache_ctrl;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          proc_read, proc_write;
   logic [29:0]   proc_addr;
   logic [31:0]   proc_wdata;
   logic [31:0]   proc_rdata;
   logic          proc_stall;
   logic          mem_read, mem_write;
   logic [27:0]   mem_addr;
   logic [127:0]  mem_wdata;
   logic [127:0]  mem_rdata;
   logic          mem_ready;
`ifdef DCACHE_STATS_EN
   logic [31:0]   stat_hit, stat_miss;
`endif

   always #5 clk = ~clk;

   dcache_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .proc_read  (proc_read),
      .proc_write (proc_write),
      .proc_addr  (proc_addr),
      .proc_wdata (proc_wdata),
      .proc_rdata (proc_rdata),
      .proc_stall (proc_stall),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
`ifdef DCACHE_STATS_EN
      ,
      .stat_hit   (stat_hit),
      .stat_miss  (stat_miss)
`endif
   );

   localparam int K_WB = 0, K_RD = 1, K_RDONE = 2, K_WDONE = 3;
   typedef struct {
      int           kind;
      logic [27:0]  addr;
      logic [127:0] data;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   logic inject_ready = 1'b0;

   logic [127:0] sim_mem [logic [27:0]];
   logic [127:0] ref_mem [logic [27:0]];
   logic         rv [8];
   logic         rdty [8];
   logic [24:0]  rt [8];
   logic [127:0] rl [8];

   function automatic logic [127:0] mem_init(input logic [27:0] b);
      logic [127:0] v;
      for (int w = 0; w < 4; w++)
         v[w*32 +: 32] = (({4'h0, b} << 2) | 32'(w)) * 32'h9E37_79B1 ^ 32'h1234_5678;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Memory responder: random latency, one-cycle ready pulse.
   initial begin
      int cnt;
      int lat;
      cnt = 0;
      lat = 5;
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (mem_ready) begin
            mem_ready = 1'b0;
            cnt = 0;
            lat = $urandom_range(1, 6);
         end else if (inject_ready) begin
            mem_ready = 1'b1;
            mem_rdata = {4{32'hDEAD_BEEF}};
            inject_ready = 1'b0;
         end else if (mem_read || mem_write) begin
            cnt++;
            if (cnt >= lat) begin
               mem_ready = 1'b1;
               if (mem_write) sim_mem[mem_addr] = mem_wdata;
               else mem_rdata = sim_mem.exists(mem_addr) ? sim_mem[mem_addr] : mem_init(mem_addr);
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT completes something.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) continue;
         if (mem_read || mem_write) chk("mem_excl", mem_read && mem_write, 1'b0);
         if (mem_ready && (mem_read || mem_write)) begin
            if (q.size() == 0) begin
               chk("unexpected_mem", 1'b1, 1'b0);
            end else begin
               e = q.pop_front();
               chk("mem_kind", mem_write ? K_WB : K_RD, e.kind);
               chk("mem_addr", mem_addr, e.addr);
               if (mem_write) chk("mem_wdata", mem_wdata, e.data);
            end
         end
         if ((proc_read || proc_write) && !proc_stall) begin
            if (q.size() == 0) begin
               chk("unexpected_done", 1'b1, 1'b0);
            end else begin
               e = q.pop_front();
               chk("done_kind", proc_write ? K_WDONE : K_RDONE, e.kind);
               if (!proc_write) chk("proc_rdata", proc_rdata, e.data);
            end
         end
      end
   end

   task automatic model_access(input logic wr, input logic [29:0] a,
                               input logic [31:0] wd, output logic hit);
      logic [2:0]  idx;
      logic [24:0] tag;
      logic [1:0]  off;
      logic [27:0] vb;
      idx = a[4:2];
      tag = a[29:5];
      off = a[1:0];
      hit = rv[idx] && (rt[idx] == tag);
      if (!hit) begin
         if (rv[idx] && rdty[idx]) begin
            vb = {rt[idx], idx};
            q.push_back('{K_WB, vb, rl[idx]});
            ref_mem[vb] = rl[idx];
         end
         q.push_back('{K_RD, a[29:2], 128'd0});
         rl[idx]   = ref_mem.exists(a[29:2]) ? ref_mem[a[29:2]] : mem_init(a[29:2]);
         rv[idx]   = 1'b1;
         rdty[idx] = 1'b0;
         rt[idx]   = tag;
      end
      if (wr) begin
         rl[idx][off*32 +: 32] = wd;
         rdty[idx] = 1'b1;
         q.push_back('{K_WDONE, 28'd0, 128'd0});
      end else begin
         q.push_back('{K_RDONE, 28'd0, {96'd0, rl[idx][off*32 +: 32]}});
      end
   endtask

   task automatic finish_now();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "bench stopped early");
   endtask

   task automatic do_req(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] wd);
      logic hit;
      int   stalls;
      model_access(wr, a, wd, hit);
      proc_read  = rd;
      proc_write = wr;
      proc_addr  = a;
      proc_wdata = wd;
      stalls = 0;
      @(negedge clk);
      while (proc_stall && stalls < 200) begin
         stalls++;
         @(negedge clk);
      end
      if (proc_stall) begin
         n_fail++;
         $display("FAIL req_timeout: addr %h still stalled after 200 cycles", a);
         finish_now();
      end
      chk("hit_nostall", stalls == 0, hit);
      @(posedge clk); #1;
      proc_read  = 1'b0;
      proc_write = 1'b0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         rv[i]   = 1'b0;
         rdty[i] = 1'b0;
      end
   endtask

   initial begin
      #400000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      finish_now();
   end

   initial begin
      logic [29:0] a;
      logic        r, w;
      int          guard;
      proc_read  = 1'b0;
      proc_write = 1'b0;
      proc_addr  = '0;
      proc_wdata = '0;
      rst_n      = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mem_read", mem_read, 1'b0);
      chk("rst_mem_write", mem_write, 1'b0);
      chk("rst_stall", proc_stall, 1'b0);
      chk("rst_rdata", proc_rdata, 32'd0);
      rst_n = 1'b1;

      // Cold miss, store hit, load hit, dirty conflict eviction.
      do_req(1'b1, 1'b0, 30'h10, 32'd0);
      do_req(1'b0, 1'b1, 30'h11, 32'h55);
      do_req(1'b1, 1'b0, 30'h11, 32'd0);
      do_req(1'b1, 1'b0, 30'h31, 32'd0);

      // Stray ready while idle must not disturb anything.
      inject_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("idle_mem_read", mem_read, 1'b0);
         chk("idle_mem_write", mem_write, 1'b0);
         chk("idle_stall", proc_stall, 1'b0);
      end
      @(posedge clk); #1;
      do_req(1'b1, 1'b0, 30'h31, 32'd0);

      for (int n = 0; n < 300; n++) begin
         r = 1'($urandom_range(0, 1));
         w = 1'($urandom_range(0, 1));
         a = {25'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
         if (r || w) begin
            do_req(r, w, a, $urandom);
         end else begin
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
         end
      end

      // Clean conflict miss, reset while the fill is outstanding.
      do_req(1'b1, 1'b0, 30'hD0, 32'd0);
      model_access(1'b0, 30'hF0, 32'd0, w);
      proc_read = 1'b1;
      proc_addr = 30'hF0;
      guard = 0;
      @(negedge clk);
      while (!mem_read && guard < 50) begin
         chk("clean_no_wb", mem_write, 1'b0);
         guard++;
         @(negedge clk);
      end
      chk("alloc_seen", mem_read, 1'b1);
      rst_n     = 1'b0;
      proc_read = 1'b0;
      @(posedge clk); #1;
      chk("rst_drop_mem_read", mem_read, 1'b0);
      chk("rst_drop_stall", proc_stall, 1'b0);
      q.delete();
      model_reset();
      rst_n = 1'b1;
      do_req(1'b1, 1'b0, 30'hF0, 32'd0);
      do_req(1'b1, 1'b0, 30'hF1, 32'd0);

      repeat (2) @(posedge clk);
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
